// File: rtl/ecg_pp_pkg.sv
// ecg_pp_pkg: read-state enum and sizing constants shared by the ping-pong bank controller
package ecg_pp_pkg;
  typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_DRAIN} rd_state_t;
  localparam int DEF_ADDR_W = 12;
  localparam int MIN_LEN = 2;
endpackage

// File: rtl/pingpong_bank_ctrl_rd_lat_pipe.sv
// rd_lat_pipe: RD_LAT-deep valid shift register; in_v (rd_en) emerges as out_v (rd_pair_valid), cleared by rst
module rd_lat_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_v,
  output logic out_v
);
  logic [RD_LAT-1:0] sr;
  always_ff @(posedge clk) sr <= rst ? '0 : (sr << 1) | RD_LAT'(in_v);
  assign out_v = sr[RD_LAT-1];
endmodule

// File: rtl/pingpong_bank_ctrl.sv
// pingpong_bank_ctrl: ping-pong BRAM sequencer (clk/rst, load; wr_valid/wr_ready/wr_en/wr_addr; rd_ready/rd_en/addra/addrb/rd_pair_valid; bank, frame_done, overrun); PPB_OVERRUN_DROP_EN drops samples instead of back-pressuring
module pingpong_bank_ctrl
  import ecg_pp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] load,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  input  logic              rd_ready,
  output logic              rd_en,
  output logic [ADDR_W:0]   addra,
  output logic [ADDR_W:0]   addrb,
  output logic              rd_pair_valid,
  output logic              bank,
  output logic              frame_done,
  output logic              overrun
);
  logic [ADDR_W-1:0] wr_off, wr_len, rd_off, rd_len, even_len, san_len;
  logic              wr_full, rd_bank, swap, wr_acc, rd_last;
  logic [1:0]        drain_cnt;
  rd_state_t         state, state_nxt;
  assign even_len = {load[ADDR_W-1:1], 1'b0};
  assign san_len  = even_len < ADDR_W'(MIN_LEN) ? ADDR_W'(MIN_LEN) : even_len;
  assign swap     = wr_full & (state == RD_IDLE);
  assign wr_acc   = wr_valid & ~wr_full;
  assign wr_en    = wr_acc;
  assign wr_addr  = {bank, wr_off};
  assign addra    = {rd_bank, rd_off};
  assign addrb    = {rd_bank, rd_off | ADDR_W'(1)};
  assign rd_last  = rd_off == rd_len - ADDR_W'(MIN_LEN);
`ifdef PPB_OVERRUN_DROP_EN
  assign wr_ready = 1'b1;
  always_ff @(posedge clk) overrun <= rst ? 1'b0 : overrun | (wr_valid & wr_full);
`else
  assign wr_ready = ~wr_full;
  assign overrun  = 1'b0;
`endif
  always_comb begin
    rd_en     = (state == RD_READ) & rd_ready;
    state_nxt = swap ? RD_READ :
                (state == RD_READ && rd_en && rd_last) ? RD_DRAIN :
                (state == RD_DRAIN && drain_cnt == 2'(RD_LAT-1)) ? RD_IDLE : state;
  end
  always_ff @(posedge clk) state <= rst ? RD_IDLE : state_nxt;
  // rd_bank is a register rather than ~bank so addra reads 0 until the first swap
  always_ff @(posedge clk) begin
    if (rst) begin
      bank       <= 1'b0;
      rd_bank    <= 1'b0;
      wr_off     <= '0;
      wr_full    <= 1'b0;
      wr_len     <= san_len;
      rd_len     <= '0;
      rd_off     <= '0;
      drain_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= swap;
      drain_cnt  <= state == RD_DRAIN ? drain_cnt + 2'd1 : 2'd0;
      if (swap) begin
        bank    <= ~bank;
        rd_bank <= bank;
        wr_off  <= '0;
        wr_full <= 1'b0;
        rd_len  <= wr_len;
        wr_len  <= san_len;
        rd_off  <= '0;
      end else begin
        if (wr_acc && wr_off == wr_len - ADDR_W'(1)) wr_full <= 1'b1;
        else if (wr_acc) wr_off <= wr_off + ADDR_W'(1);
        if (rd_en && !rd_last) rd_off <= rd_off + ADDR_W'(2);
      end
    end
  end
  rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .in_v (rd_en),
    .out_v(rd_pair_valid)
  );
endmodule
